control_unit: RTL and testbench

//  Microcoded control unit of the 8-bit SAP-style CPU. Each instruction runs as a

---
 rtl/cu_pkg.sv | 55 +++++
 rtl/cu_step_counter.sv | 39 +++
 rtl/control_unit.sv | 138 +++++++++++++
 tb/tb_control_unit.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared definitions for the SAP-style control unit: opcodes, microstep encodings,
// control-word bit positions and the per-opcode last execute step.
package cu_pkg;

    localparam int STEPS    = 5;
    localparam int CW_WIDTH = 16;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Control word is ordered h,mi,ri,ro,io,ii,ai,ao,eo,su,bi,oi,ce,co,j,f from MSB down.
    localparam int CW_H  = 15;
    localparam int CW_MI = 14;
    localparam int CW_RI = 13;
    localparam int CW_RO = 12;
    localparam int CW_IO = 11;
    localparam int CW_II = 10;
    localparam int CW_AI = 9;
    localparam int CW_AO = 8;
    localparam int CW_EO = 7;
    localparam int CW_SU = 6;
    localparam int CW_BI = 5;
    localparam int CW_OI = 4;
    localparam int CW_CE = 3;
    localparam int CW_CO = 2;
    localparam int CW_J  = 1;
    localparam int CW_F  = 0;

    // Last microstep that drives anything; a JC/JZ not taken still ends at T2.
    function automatic step_t last_exec_step(input logic [3:0] op);
        case (op)
            OP_LDA, OP_STA: return T3;
            OP_ADD, OP_SUB: return T4;
            default:        return T2;
        endcase
    endfunction

endpackage

// File: rtl/cu_step_counter.sv
// Microstep counter: wraps after the last step, holds while halted and can
// return to T0 early when the decoder signals the instruction is done.
module cu_step_counter
    import cu_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  halt_i,
    input  logic  early_end_i,
    output step_t step_o
);

    localparam step_t LAST_STEP = step_t'(3'(STEPS - 1));

    step_t step_q;
    step_t step_d;

    always_comb begin
        step_d = step_q;
        if (halt_i) begin
            step_d = step_q;
        end else if (early_end_i || (step_q >= LAST_STEP)) begin
            step_d = T0;
        end else begin
            step_d = step_t'(step_q + 3'd1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            step_q <= T0;
        end else begin
            step_q <= step_d;
        end
    end

    assign step_o = step_q;

endmodule

// File: rtl/control_unit.sv
// Microcoded control unit: decodes {step, opcode, flags} into 16 control lines.
// Define CU_EARLY_END_EN to end each instruction after its last non-empty step.
module control_unit
    import cu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cu_ins,
    input  logic       cu_f1,
    input  logic       cu_f0,
    output logic       cu_h,
    output logic       cu_mi,
    output logic       cu_ri,
    output logic       cu_ro,
    output logic       cu_io,
    output logic       cu_ii,
    output logic       cu_ai,
    output logic       cu_ao,
    output logic       cu_eo,
    output logic       cu_su,
    output logic       cu_bi,
    output logic       cu_oi,
    output logic       cu_ce,
    output logic       cu_co,
    output logic       cu_j,
    output logic       cu_f
);

    step_t               step;
    logic [CW_WIDTH-1:0] ctrlWord;
    logic                earlyEnd;

    cu_step_counter u_step_counter (
        .clk_i       (clk),
        .rst_i       (rst),
        .halt_i      (ctrlWord[CW_H]),
        .early_end_i (earlyEnd),
        .step_o      (step)
    );

`ifdef CU_EARLY_END_EN
    assign earlyEnd = (step == last_exec_step(cu_ins));
`else
    assign earlyEnd = 1'b0;
`endif

    // Flags and opcode are used live, so a flag change during T2 moves cu_j immediately.
    always_comb begin
        ctrlWord = '0;
        if (!rst) begin
            case (step)
                T0: begin
                    ctrlWord[CW_CO] = 1'b1;
                    ctrlWord[CW_MI] = 1'b1;
                end
                T1: begin
                    ctrlWord[CW_RO] = 1'b1;
                    ctrlWord[CW_II] = 1'b1;
                    ctrlWord[CW_CE] = 1'b1;
                end
                T2: begin
                    case (cu_ins)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            ctrlWord[CW_IO] = 1'b1;
                            ctrlWord[CW_MI] = 1'b1;
                        end
                        OP_LDI: begin
                            ctrlWord[CW_IO] = 1'b1;
                            ctrlWord[CW_AI] = 1'b1;
                        end
                        OP_JMP: begin
                            ctrlWord[CW_IO] = 1'b1;
                            ctrlWord[CW_J]  = 1'b1;
                        end
                        OP_JC: begin
                            ctrlWord[CW_IO] = cu_f1;
                            ctrlWord[CW_J]  = cu_f1;
                        end
                        OP_JZ: begin
                            ctrlWord[CW_IO] = cu_f0;
                            ctrlWord[CW_J]  = cu_f0;
                        end
                        OP_OUT: begin
                            ctrlWord[CW_AO] = 1'b1;
                            ctrlWord[CW_OI] = 1'b1;
                        end
                        OP_HLT: ctrlWord[CW_H] = 1'b1;
                        default: ;
                    endcase
                end
                T3: begin
                    case (cu_ins)
                        OP_LDA: begin
                            ctrlWord[CW_RO] = 1'b1;
                            ctrlWord[CW_AI] = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ctrlWord[CW_RO] = 1'b1;
                            ctrlWord[CW_BI] = 1'b1;
                        end
                        OP_STA: begin
                            ctrlWord[CW_AO] = 1'b1;
                            ctrlWord[CW_RI] = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    if ((cu_ins == OP_ADD) || (cu_ins == OP_SUB)) begin
                        ctrlWord[CW_EO] = 1'b1;
                        ctrlWord[CW_AI] = 1'b1;
                        ctrlWord[CW_F]  = 1'b1;
                        ctrlWord[CW_SU] = (cu_ins == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign cu_h  = ctrlWord[CW_H];
    assign cu_mi = ctrlWord[CW_MI];
    assign cu_ri = ctrlWord[CW_RI];
    assign cu_ro = ctrlWord[CW_RO];
    assign cu_io = ctrlWord[CW_IO];
    assign cu_ii = ctrlWord[CW_II];
    assign cu_ai = ctrlWord[CW_AI];
    assign cu_ao = ctrlWord[CW_AO];
    assign cu_eo = ctrlWord[CW_EO];
    assign cu_su = ctrlWord[CW_SU];
    assign cu_bi = ctrlWord[CW_BI];
    assign cu_oi = ctrlWord[CW_OI];
    assign cu_ce = ctrlWord[CW_CE];
    assign cu_co = ctrlWord[CW_CO];
    assign cu_j  = ctrlWord[CW_J];
    assign cu_f  = ctrlWord[CW_F];

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit against a microstep-table reference model;
// honours CU_EARLY_END_EN when the design is built with it.
module tb_control_unit;

    localparam logic [15:0] M_H  = 16'h8000;
    localparam logic [15:0] M_MI = 16'h4000;
    localparam logic [15:0] M_RI = 16'h2000;
    localparam logic [15:0] M_RO = 16'h1000;
    localparam logic [15:0] M_IO = 16'h0800;
    localparam logic [15:0] M_II = 16'h0400;
    localparam logic [15:0] M_AI = 16'h0200;
    localparam logic [15:0] M_AO = 16'h0100;
    localparam logic [15:0] M_EO = 16'h0080;
    localparam logic [15:0] M_SU = 16'h0040;
    localparam logic [15:0] M_BI = 16'h0020;
    localparam logic [15:0] M_OI = 16'h0010;
    localparam logic [15:0] M_CE = 16'h0008;
    localparam logic [15:0] M_CO = 16'h0004;
    localparam logic [15:0] M_J  = 16'h0002;
    localparam logic [15:0] M_F  = 16'h0001;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ins;
    logic       f1;
    logic       f0;
    logic cu_h, cu_mi, cu_ri, cu_ro, cu_io, cu_ii, cu_ai, cu_ao;
    logic cu_eo, cu_su, cu_bi, cu_oi, cu_ce, cu_co, cu_j, cu_f;
    logic [15:0] obsWord;

    int passCount  = 0;
    int checkCount = 0;
    int mStep      = 0;

    control_unit dut (
        .clk    (clk),
        .rst    (rst),
        .cu_ins (ins),
        .cu_f1  (f1),
        .cu_f0  (f0),
        .cu_h   (cu_h),
        .cu_mi  (cu_mi),
        .cu_ri  (cu_ri),
        .cu_ro  (cu_ro),
        .cu_io  (cu_io),
        .cu_ii  (cu_ii),
        .cu_ai  (cu_ai),
        .cu_ao  (cu_ao),
        .cu_eo  (cu_eo),
        .cu_su  (cu_su),
        .cu_bi  (cu_bi),
        .cu_oi  (cu_oi),
        .cu_ce  (cu_ce),
        .cu_co  (cu_co),
        .cu_j   (cu_j),
        .cu_f   (cu_f)
    );

    always #5 clk = ~clk;

    assign obsWord = {cu_h, cu_mi, cu_ri, cu_ro, cu_io, cu_ii, cu_ai, cu_ao,
                      cu_eo, cu_su, cu_bi, cu_oi, cu_ce, cu_co, cu_j, cu_f};

    // Instruction table: fetch is common, then each opcode lists its three execute steps.
    function automatic logic [15:0] expWord(input logic r, input logic [3:0] op,
                                            input int st, input logic fc, input logic fz);
        logic [15:0] ex [3];
        ex[0] = 16'h0; ex[1] = 16'h0; ex[2] = 16'h0;
        case (op)
            4'd1: begin ex[0] = M_IO | M_MI; ex[1] = M_RO | M_AI; end
            4'd2: begin ex[0] = M_IO | M_MI; ex[1] = M_RO | M_BI; ex[2] = M_EO | M_AI | M_F; end
            4'd3: begin ex[0] = M_IO | M_MI; ex[1] = M_RO | M_BI; ex[2] = M_EO | M_AI | M_SU | M_F; end
            4'd4: begin ex[0] = M_IO | M_MI; ex[1] = M_AO | M_RI; end
            4'd5: ex[0] = M_IO | M_AI;
            4'd6: ex[0] = M_IO | M_J;
            4'd7: ex[0] = fc ? (M_IO | M_J) : 16'h0;
            4'd8: ex[0] = fz ? (M_IO | M_J) : 16'h0;
            4'd14: ex[0] = M_AO | M_OI;
            4'd15: ex[0] = M_H;
            default: ;
        endcase
        if (r) return 16'h0;
        if (st == 0) return M_CO | M_MI;
        if (st == 1) return M_RO | M_II | M_CE;
        return ex[st - 2];
    endfunction

    // Number of microsteps an instruction occupies when it may finish early.
    function automatic int instrLength(input logic [3:0] op);
        if (op == 4'd1 || op == 4'd4) return 4;
        if (op == 4'd2 || op == 4'd3) return 5;
        return 3;
    endfunction

    task automatic driveInputs(input logic r, input logic [3:0] op, input logic c, input logic z);
        @(negedge clk);
        rst = r;
        ins = op;
        f1  = c;
        f0  = z;
        #1;
    endtask

    // Advance the reference step across one rising edge using the inputs held there.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            mStep = 0;
        end else if (ins == 4'd15 && mStep == 2) begin
            mStep = 2;
        end else begin
            mStep = mStep + 1;
`ifdef CU_EARLY_END_EN
            if (mStep >= instrLength(ins)) mStep = 0;
`else
            if (mStep >= 5) mStep = 0;
`endif
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            driveInputs(1'b1, 4'd1, 1'b0, 1'b0);
            checkCount++;
            if (obsWord !== 16'h0) $display("[TB] FAIL reset_hold got=%h want=%h", obsWord, 16'h0);
            else passCount++;
            tick();
        end
        for (int i = 0; i < 12; i++) begin
            logic [15:0] e;
            driveInputs(1'b0, 4'd1, 1'b0, 1'b0);
            e = expWord(1'b0, 4'd1, mStep, 1'b0, 1'b0);
            checkCount++;
            if (obsWord !== e) $display("[TB] FAIL lda_seq cyc=%0d got=%h want=%h", i, obsWord, e);
            else passCount++;
            tick();
        end
    endtask

    task automatic test_alu();
        logic [3:0] ops [2];
        ops[0] = 4'd3;
        ops[1] = 4'd2;
        for (int k = 0; k < 2; k++) begin
            driveInputs(1'b1, ops[k], 1'b0, 1'b0);
            tick();
            for (int i = 0; i < 5; i++) begin
                logic [15:0] e;
                driveInputs(1'b0, ops[k], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                e = expWord(1'b0, ops[k], mStep, f1, f0);
                if (i == 4) e = M_EO | M_AI | M_F | ((ops[k] == 4'd3) ? M_SU : 16'h0);
                checkCount++;
                if (obsWord !== e) $display("[TB] FAIL alu op=%0d cyc=%0d got=%h want=%h", ops[k], i, obsWord, e);
                else passCount++;
                tick();
            end
        end
    endtask

    task automatic test_jumps();
        logic [3:0] ops [4];
        logic       fcs [4];
        logic       fzs [4];
        ops[0] = 4'd7; fcs[0] = 1'b0; fzs[0] = 1'b1;
        ops[1] = 4'd7; fcs[1] = 1'b1; fzs[1] = 1'b0;
        ops[2] = 4'd8; fcs[2] = 1'b1; fzs[2] = 1'b1;
        ops[3] = 4'd8; fcs[3] = 1'b1; fzs[3] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            driveInputs(1'b1, ops[k], fcs[k], fzs[k]);
            tick();
            for (int i = 0; i < 3; i++) begin
                logic [15:0] e;
                driveInputs(1'b0, ops[k], fcs[k], fzs[k]);
                e = expWord(1'b0, ops[k], mStep, fcs[k], fzs[k]);
                checkCount++;
                if (obsWord !== e) $display("[TB] FAIL jump op=%0d case=%0d cyc=%0d got=%h want=%h", ops[k], k, i, obsWord, e);
                else passCount++;
                tick();
            end
        end
    endtask

    task automatic test_halt();
        driveInputs(1'b1, 4'd15, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 15; i++) begin
            logic [15:0] e;
            driveInputs(1'b0, 4'd15, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            e = (i >= 2) ? M_H : expWord(1'b0, 4'd15, mStep, f1, f0);
            checkCount++;
            if (obsWord !== e) $display("[TB] FAIL halt cyc=%0d got=%h want=%h", i, obsWord, e);
            else passCount++;
            tick();
        end
        driveInputs(1'b1, 4'd15, 1'b0, 1'b0);
        checkCount++;
        if (obsWord !== 16'h0) $display("[TB] FAIL halt_reset got=%h want=%h", obsWord, 16'h0);
        else passCount++;
        tick();
        driveInputs(1'b0, 4'd15, 1'b0, 1'b0);
        checkCount++;
        if (obsWord !== (M_CO | M_MI)) $display("[TB] FAIL halt_refetch got=%h want=%h", obsWord, M_CO | M_MI);
        else passCount++;
        tick();
    endtask

    task automatic test_reset_mid();
        driveInputs(1'b1, 4'd2, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            driveInputs(1'b0, 4'd2, 1'b0, 1'b0);
            tick();
        end
        driveInputs(1'b1, 4'd2, 1'b0, 1'b0);
        checkCount++;
        if (obsWord !== 16'h0) $display("[TB] FAIL midreset_hold got=%h want=%h", obsWord, 16'h0);
        else passCount++;
        tick();
        for (int i = 0; i < 5; i++) begin
            logic [15:0] e;
            driveInputs(1'b0, 4'd2, 1'b0, 1'b0);
            e = expWord(1'b0, 4'd2, mStep, 1'b0, 1'b0);
            if (i == 0) e = M_CO | M_MI;
            checkCount++;
            if (obsWord !== e) $display("[TB] FAIL midreset_refetch cyc=%0d got=%h want=%h", i, obsWord, e);
            else passCount++;
            tick();
        end
    endtask

    task automatic test_period();
        logic [3:0] ops [2];
        ops[0] = 4'd5;
        ops[1] = 4'd2;
        for (int k = 0; k < 2; k++) begin
            driveInputs(1'b1, ops[k], 1'b0, 1'b0);
            tick();
            for (int i = 0; i < 11; i++) begin
                logic [15:0] e;
                int pos;
`ifdef CU_EARLY_END_EN
                pos = i % instrLength(ops[k]);
`else
                pos = i % 5;
`endif
                driveInputs(1'b0, ops[k], 1'b0, 1'b0);
                e = expWord(1'b0, ops[k], pos, 1'b0, 1'b0);
                checkCount++;
                if (obsWord !== e) $display("[TB] FAIL period op=%0d cyc=%0d got=%h want=%h", ops[k], i, obsWord, e);
                else passCount++;
                tick();
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] op;
        op = 4'd0;
        for (int i = 0; i < 400; i++) begin
            logic [15:0] e;
            logic        r;
            r = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 3) == 0) op = 4'($urandom_range(0, 15));
            driveInputs(r, op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            e = expWord(r, op, mStep, f1, f0);
            checkCount++;
            if (obsWord !== e) $display("[TB] FAIL random cyc=%0d op=%0d step=%0d got=%h want=%h", i, op, mStep, obsWord, e);
            else passCount++;
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        ins = 4'd1;
        f1  = 1'b0;
        f0  = 1'b0;
        test_reset();
        test_alu();
        test_jumps();
        test_halt();
        test_reset_mid();
        test_period();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
